// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, 4-bit ALU commands and argument bundle shared by the nibble sequencer.
package alu_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_SHR} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic CMD_SUM = 1'b0;
  localparam logic CMD_SHR = 1'b1;
  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       cmd;
    logic       carry_in;
    logic       carry_disable;
  } Alu4bitArgs;
endpackage

// File: rtl/alu_nibble_seq_if.sv
// alu_nibble_seq_if: request/response handshake bundle between requester, sequencer and consumer.
interface alu_nibble_seq_if #(parameter int NIBBLES = 4) ();
  import alu_pkg::*;
  localparam int WIDTH = 4 * NIBBLES;
  logic             req_valid;
  logic             req_ready;
  op_t              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_carry_in;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             busy;
  modport master (output req_valid, req_op, req_a, req_b, req_carry_in, rsp_ready,
                  input req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, busy);
  modport slave (input req_valid, req_op, req_a, req_b, req_carry_in, rsp_ready,
                 output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, busy);
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit: 4-bit add / carry-less add (xor) / shift-right datapath.
module alu_4bit
  import alu_pkg::*;
(
  input  Alu4bitArgs args_i,
  output logic [3:0] res_o,
  output logic       carry_o
);
  logic [4:0] sum;
  assign sum = {1'b0, args_i.d1} + {1'b0, args_i.d2} + {4'b0, args_i.carry_in};
  always_comb begin
    res_o   = args_i.cmd == CMD_SHR ? {1'b0, args_i.d2[3:1]} :
              args_i.carry_disable ? args_i.d1 ^ args_i.d2 ^ {3'b0, args_i.carry_in} : sum[3:0];
    carry_o = args_i.cmd == CMD_SHR ? args_i.d2[0] : !args_i.carry_disable && sum[4];
  end
endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: iterates one alu_4bit over WIDTH-bit operands, LSB nibble first, carry chained in a register.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_nibble_seq_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = $clog2(NIBBLES);
  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d, shr_full;
  logic [IW-1:0]    idx_q;
  logic             cin_q, carry_q, rsp_carry_q, rsp_zero_q;
  logic             last, alu_carry;
  logic [3:0]       alu_res, nib_res;
  Alu4bitArgs       args;
  alu_4bit u_alu (.args_i(args), .res_o(alu_res), .carry_o(alu_carry));
  // Whole-word shift result supplies the bit that crosses into each nibble's MSB.
  assign shr_full = {cin_q, b_q[WIDTH-1:1]};
  assign last     = idx_q == IW'(NIBBLES - 1);
  always_comb begin
    args.d1            = a_q[{idx_q, 2'b00} +: 4];
    args.d2            = op_q == OP_SUB ? ~b_q[{idx_q, 2'b00} +: 4] : b_q[{idx_q, 2'b00} +: 4];
    args.cmd           = op_q == OP_SHR ? CMD_SHR : CMD_SUM;
    args.carry_disable = op_q == OP_XOR || op_q == OP_SHR;
    args.carry_in      = op_q == OP_ADD || op_q == OP_SUB ?
                         (idx_q == '0 ? op_q == OP_SUB || cin_q : carry_q) : 1'b0;
    nib_res            = op_q == OP_SHR ? {shr_full[{idx_q, 2'b11}], alu_res[2:0]} : alu_res;
    result_d           = result_q;
    result_d[{idx_q, 2'b00} +: 4] = nib_res;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          a_q     <= bus.req_a;
          b_q     <= bus.req_b;
          cin_q   <= bus.req_carry_in;
          idx_q   <= '0;
          carry_q <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= alu_carry;
          idx_q    <= last ? idx_q : idx_q + 1'b1;
          if (last) begin
            state_q     <= S_DONE;
            rsp_carry_q <= op_q == OP_SHR ? b_q[0] : op_q != OP_XOR && alu_carry;
            rsp_zero_q  <= ~|result_d;
          end
        end
        S_DONE: if (bus.rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.req_ready  = state_q == S_IDLE;
  assign bus.rsp_valid  = state_q == S_DONE;
  assign bus.busy       = state_q != S_IDLE;
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed vectors into a scoreboard queue, checked by a decoupled response monitor.
module tb_alu_nibble_seq;
  import alu_pkg::*;
  typedef struct {logic [15:0] r; logic c; logic z;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  alu_nibble_seq_if #(.NIBBLES(4)) bus ();
  alu_nibble_seq #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input op_t op, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] er, input logic ec, input bit push);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_carry_in = cin;
    if (push) q.push_back('{er, ec, er == 16'h0});
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a = 16'hDEAD;
    bus.req_b = 16'hBEEF;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  // Monitor samples shortly after the falling edge so stimulus written on that edge is settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_result), 32'hFFFFFFFF);
        else begin
          e = q.pop_front();
          chk("rsp_result", 32'(bus.rsp_result), 32'(e.r));
          chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
          chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.z));
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] r0;
    logic        c0, z0;
    bus.req_valid = 1'b0;
    bus.req_op = OP_ADD;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_carry_in = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_carry", 32'(bus.rsp_carry), 32'd0);
    chk("rst_zero", 32'(bus.rsp_zero), 32'd0);
    rst_n = 1'b1;
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    chk("lat_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("lat_not_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(bus.rsp_valid), 32'd1);
    issue(OP_SUB, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b0, 1);
    issue(OP_SUB, 16'h5000, 16'h1000, 1'b0, 16'h4000, 1'b1, 1);
    issue(OP_XOR, 16'hA5A5, 16'h0FF0, 1'b1, 16'hAA55, 1'b0, 1);
    issue(OP_SHR, 16'h1111, 16'h8001, 1'b1, 16'hC000, 1'b1, 1);
    issue(OP_SHR, 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b0, 1);
    drain();
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1);
    fork
      issue(OP_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1);
      begin
        int n = 0;
        while (!bus.rsp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        r0 = bus.rsp_result;
        c0 = bus.rsp_carry;
        z0 = bus.rsp_zero;
        repeat (5) begin
          @(negedge clk);
          chk("bp_result_stable", 32'(bus.rsp_result), 32'(r0));
          chk("bp_carry_stable", 32'(bus.rsp_carry), 32'(c0));
          chk("bp_zero_stable", 32'(bus.rsp_zero), 32'(z0));
          chk("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
          chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain();
    issue(OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_result", 32'(bus.rsp_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    issue(OP_ADD, 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
